// File: rtl/l2_refill_ctrl_pkg.sv
// Shared constants for the L2 instruction-cache refill engine: geometry,
// refill FSM state codes and the beat address helper.
package l2_refill_ctrl_pkg;

  localparam int unsigned BEAT_W  = 128;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned LINE_W  = BEAT_W * BEATS;
  localparam int unsigned LADDR_W = 26;
  localparam int unsigned SEL_W   = $clog2(BEATS);

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Refill FSM state codes, kept as plain constants so legacy code that
  // compares raw 3-bit state values keeps working.
  localparam logic [2:0] L2R_IDLE  = 3'd0;
  localparam logic [2:0] L2R_FETCH = 3'd1;
  localparam logic [2:0] L2R_WRITE = 3'd2;
  localparam logic [2:0] L2R_DONE  = 3'd3;
  localparam logic [2:0] L2R_HOLD  = 3'd4;

  // Byte address of one 16-byte beat inside a 64-byte line.
  function automatic logic [31:0] beat_addr(input logic [LADDR_W-1:0] line_addr,
                                            input logic [SEL_W-1:0]   idx);
    return {line_addr, idx, 4'b0000};
  endfunction

endpackage

// File: rtl/l2_refill_ctrl_if.sv
// Request/memory/array bundle of the refill engine. The refill engine uses
// the master view; the L2 control, memory and arrays sit on the slave view.
interface l2_refill_ctrl_if
  import l2_refill_ctrl_pkg::*;
();

  logic                  miss_req;
  logic [LADDR_W-1:0]    miss_addr;
  logic [SEL_W-1:0]      miss_offset;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic [BEAT_W-1:0]     mem_rdata;
  logic [LINE_W-1:0]     L2_data_wd;
  logic                  L2_wr_en;
  logic                  L2_complete;
  logic                  refill_busy;

  modport master (
    input  miss_req, miss_addr, miss_offset, mem_ack, mem_rdata,
    output mem_req, mem_addr, L2_data_wd, L2_wr_en, L2_complete, refill_busy
  );

  modport slave (
    output miss_req, miss_addr, miss_offset, mem_ack, mem_rdata,
    input  mem_req, mem_addr, L2_data_wd, L2_wr_en, L2_complete, refill_busy
  );

endinterface

// File: rtl/l2_line_asm.sv
// Line assembly register: BEATS slots of BEAT_W bits, one slot written per
// accepted beat, presented as a flat line with slot k at bits [k*BEAT_W +: BEAT_W].
module l2_line_asm #(
  parameter int unsigned BEAT_W = 128,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned SEL_W  = $clog2(BEATS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [SEL_W-1:0]         sel,
  input  logic [BEAT_W-1:0]        wdata,
  output logic [BEAT_W*BEATS-1:0]  line
);

  logic [BEAT_W-1:0] slots [BEATS];

  // Capture one beat into its slot; contents hold until overwritten.
  // NOTE: this storage is reset because the assembled line is a visible
  // output that must read as zero after reset; a plain RAM would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BEATS; k++) slots[k] <= '0;
    end else if (we) begin
      slots[sel] <= wdata;
    end
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_flat
    assign line[k*BEAT_W +: BEAT_W] = slots[k];
  end

endmodule

// File: rtl/l2_refill_ctrl.sv
// L2 instruction-cache refill engine: fetches a 64-byte line as four 128-bit
// beats, critical beat first, assembles it, then strobes the L2 arrays and
// signals completion. The request must drop before another refill starts.
module l2_refill_ctrl
  import l2_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  l2_refill_ctrl_if.master  bus
);

  logic [2:0]         state;
  logic [LADDR_W-1:0] line_addr;
  logic [SEL_W-1:0]   beat_idx;
  logic [SEL_W-1:0]   cnt;
  logic               beat_take;

  // A beat is accepted only while requesting; stray acks elsewhere are dropped.
  assign beat_take = (state == L2R_FETCH) && bus.mem_ack;

  // Refill sequencing, latched request and beat counters.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let cnt/beat_idx race each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= L2R_IDLE;
      line_addr <= '0;
      beat_idx  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        L2R_IDLE: begin
          if (bus.miss_req) begin
            line_addr <= bus.miss_addr;
            beat_idx  <= bus.miss_offset;
            cnt       <= '0;
            state     <= L2R_FETCH;
          end
        end
        L2R_FETCH: begin
          if (bus.mem_ack) begin
            beat_idx <= beat_idx + 1'b1;
            cnt      <= cnt + 1'b1;
            if (cnt == SEL_W'(BEATS - 1)) state <= L2R_WRITE;
          end
        end
        L2R_WRITE: state <= L2R_DONE;
        L2R_DONE:  state <= L2R_HOLD;
        L2R_HOLD:  if (!bus.miss_req) state <= L2R_IDLE;
        default:   state <= L2R_IDLE;
      endcase
    end
  end

  // Outputs decode directly from state, so a reset clears them immediately.
  assign bus.mem_req     = (state == L2R_FETCH) ? ENABLE : DISABLE;
  assign bus.mem_addr    = (state == L2R_FETCH) ? beat_addr(line_addr, beat_idx) : '0;
  assign bus.L2_wr_en    = (state == L2R_WRITE) ? ENABLE : DISABLE;
  assign bus.L2_complete = (state == L2R_DONE)  ? ENABLE : DISABLE;
  assign bus.refill_busy = (state != L2R_IDLE)  ? ENABLE : DISABLE;

  l2_line_asm #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .SEL_W  (SEL_W)
  ) u_line_asm (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_take),
    .sel   (beat_idx),
    .wdata (bus.mem_rdata),
    .line  (bus.L2_data_wd)
  );

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Self-checking bench for l2_refill_ctrl: expected beat addresses are queued
// when a request is raised and popped as the memory model acks each beat;
// the expected line is built from the same address-derived beat data.
`timescale 1ns/1ps
module tb_l2_refill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  l2_refill_ctrl_if bus ();

  l2_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0]  exp_addr_q [$];
  logic [511:0] exp_line = '0;
  logic [31:0]  salt;
  int           wr_tick;
  int           done_tick;

  function automatic logic [127:0] beat_data(input logic [31:0] a, input logic [31:0] s);
    return {s, a, ~a, s ^ a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full refill; checks every beat address, the line, and the strobes.
  task automatic do_refill(input logic [25:0] la, input logic [1:0] off,
                           input int max_gap, input bit drop_mid, input bit release_req);
    int          ticks;
    int          gap;
    logic [31:0] a;
    salt = $urandom;
    bus.miss_addr   = la;
    bus.miss_offset = off;
    bus.miss_req    = 1'b1;
    bus.mem_ack     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = {la, 2'(off + 2'(k)), 4'h0};
      exp_addr_q.push_back(a);
      exp_line[a[5:4]*128 +: 128] = beat_data(a, salt);
    end
    tick();
    ticks = 1;
    tests_run++;
    if (bus.refill_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start: got %b expected 1", bus.refill_busy);
    end
    for (int b = 0; b < 4; b++) begin
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = {4{$urandom}};
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr_q[0]) begin
          tests_failed++;
          $display("FAIL addr_stable: got req=%b addr=%h expected req=1 addr=%h",
                   bus.mem_req, bus.mem_addr, exp_addr_q[0]);
        end
        tick();
        ticks++;
      end
      a = exp_addr_q.pop_front();
      tests_run++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== a) begin
        tests_failed++;
        $display("FAIL beat_addr: got req=%b addr=%h expected req=1 addr=%h",
                 bus.mem_req, bus.mem_addr, a);
      end
      bus.mem_rdata = beat_data(a, salt);
      bus.mem_ack   = 1'b1;
      tick();
      ticks++;
      if (drop_mid && b == 1) begin
        bus.miss_req    = 1'b0;
        bus.miss_addr   = ~la;
        bus.miss_offset = ~off;
      end
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = {4{$urandom}};
    wr_tick = ticks;
    tests_run++;
    if (bus.L2_wr_en !== 1'b1 || bus.L2_complete !== 1'b0 || bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_cycle: got wr=%b cpl=%b req=%b expected wr=1 cpl=0 req=0",
               bus.L2_wr_en, bus.L2_complete, bus.mem_req);
    end
    tests_run++;
    if (bus.L2_data_wd !== exp_line) begin
      tests_failed++;
      $display("FAIL line_data: got %h expected %h", bus.L2_data_wd, exp_line);
    end
    tick();
    ticks++;
    done_tick = ticks;
    tests_run++;
    if (bus.L2_wr_en !== 1'b0 || bus.L2_complete !== 1'b1) begin
      tests_failed++;
      $display("FAIL complete_cycle: got wr=%b cpl=%b expected wr=0 cpl=1",
               bus.L2_wr_en, bus.L2_complete);
    end
    tick();
    tests_run++;
    if (bus.L2_complete !== 1'b0 || bus.refill_busy !== 1'b1 || bus.mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_state: got cpl=%b busy=%b req=%b expected cpl=0 busy=1 req=0",
               bus.L2_complete, bus.refill_busy, bus.mem_req);
    end
    if (release_req) begin
      bus.miss_req = 1'b0;
      tick();
      tests_run++;
      if (bus.refill_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL back_to_idle: got busy=%b expected 0", bus.refill_busy);
      end
    end
  endtask

  task automatic test_reset();
    bus.miss_req    = 1'b0;
    bus.miss_addr   = '0;
    bus.miss_offset = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.L2_wr_en !== 1'b0 ||
        bus.L2_complete !== 1'b0 || bus.refill_busy !== 1'b0 || bus.L2_data_wd !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b addr=%h wr=%b cpl=%b busy=%b line_nonzero=%b expected all 0",
               bus.mem_req, bus.mem_addr, bus.L2_wr_en, bus.L2_complete,
               bus.refill_busy, |bus.L2_data_wd);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus.refill_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b expected 0", bus.refill_busy);
    end
  endtask

  task automatic test_basic_latency();
    do_refill(26'h0001234, 2'd0, 0, 1'b0, 1'b1);
    tests_run++;
    if (wr_tick !== 5 || done_tick !== 6) begin
      tests_failed++;
      $display("FAIL min_latency: got wr_cycle=%0d cpl_cycle=%0d expected 5 and 6",
               wr_tick, done_tick);
    end
  endtask

  task automatic test_critical_offset();
    do_refill(26'h2ABCDEF, 2'd2, 0, 1'b0, 1'b1);
    do_refill(26'h3FFFFFF, 2'd3, 1, 1'b0, 1'b1);
  endtask

  task automatic test_ack_gaps();
    for (int r = 0; r < 4; r++) begin
      do_refill(26'($urandom), 2'($urandom_range(0, 3)), 5, 1'b0, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    salt = $urandom;
    bus.miss_addr   = 26'h155AA55;
    bus.miss_offset = 2'd1;
    bus.miss_req    = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      bus.mem_rdata = beat_data(bus.mem_addr, salt);
      bus.mem_ack   = 1'b1;
      tick();
    end
    bus.mem_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.L2_wr_en !== 1'b0 ||
        bus.L2_complete !== 1'b0 || bus.refill_busy !== 1'b0 || bus.L2_data_wd !== '0) begin
      tests_failed++;
      $display("FAIL async_abort: got req=%b addr=%h wr=%b cpl=%b busy=%b line_nonzero=%b expected all 0",
               bus.mem_req, bus.mem_addr, bus.L2_wr_en, bus.L2_complete,
               bus.refill_busy, |bus.L2_data_wd);
    end
    bus.miss_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_line = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (bus.L2_wr_en !== 1'b0 || bus.L2_complete !== 1'b0 || bus.refill_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_complete_after_abort: got wr=%b cpl=%b busy=%b expected 0",
                 bus.L2_wr_en, bus.L2_complete, bus.refill_busy);
      end
    end
    do_refill(26'h0C0FFEE, 2'd1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_hold_retrigger();
    do_refill(26'h0000042, 2'd3, 0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (bus.mem_req !== 1'b0 || bus.refill_busy !== 1'b1 || bus.L2_complete !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_no_retrigger: got req=%b busy=%b cpl=%b expected 0 1 0",
                 bus.mem_req, bus.refill_busy, bus.L2_complete);
      end
    end
    bus.miss_req = 1'b0;
    tick();
    tests_run++;
    if (bus.refill_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: got busy=%b expected 0", bus.refill_busy);
    end
    do_refill(26'h0000043, 2'd0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_stray_ack_and_drop();
    for (int c = 0; c < 3; c++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = {4{$urandom}};
      tick();
      tests_run++;
      if (bus.L2_data_wd !== exp_line || bus.refill_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ack_ignored: got busy=%b line=%h expected busy=0 line=%h",
                 bus.refill_busy, bus.L2_data_wd, exp_line);
      end
    end
    bus.mem_ack = 1'b0;
    do_refill(26'h1234567, 2'd2, 1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = {4{$urandom}};
      tick();
      tests_run++;
      if (bus.L2_data_wd !== exp_line || bus.mem_req !== 1'b0 || bus.refill_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_ack_ignored: got req=%b busy=%b line=%h expected req=0 busy=1 line=%h",
                 bus.mem_req, bus.refill_busy, bus.L2_data_wd, exp_line);
      end
    end
    bus.mem_ack  = 1'b0;
    bus.miss_req = 1'b0;
    tick();
    do_refill(26'h2468ACE, 2'd1, 3, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_critical_offset();
    test_ack_gaps();
    test_mid_reset();
    test_hold_retrigger();
    test_stray_ack_and_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
